// File: rtl/ipg_rx_extract.sv
`default_nettype none
// ============================================================================
// Module      : ipg_rx_extract
// Description : Receive-side IPG message extractor for a 64b/66b block stream.
//               IPG control blocks are removed from the pass-through stream
//               (replaced by idle blocks) and their 32-bit payload chunks are
//               reassembled into a 16-chunk message.
//               Optional statistics counters: define IPG_RX_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ipg_rx_extract #(
  parameter int          MSG_WIDTH = 512,   // must equal 32*16
  parameter logic [7:0]  IPG_BT    = 8'h77,
  parameter int          TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [1:0]           in_hdr,
  input  logic [63:0]          in_data,
  output logic                 out_valid,
  output logic [1:0]           out_hdr,
  output logic [63:0]          out_data,
  output logic [MSG_WIDTH-1:0] msg_data,
  output logic                 msg_valid,
  output logic                 msg_err
`ifdef IPG_RX_STATS_EN
  ,
  output logic [15:0]          msg_count,
  output logic [15:0]          err_count
`endif
);

  localparam int         TO_W       = $clog2(TIMEOUT + 1);
  localparam logic [1:0] HDR_CTRL   = 2'b01;
  localparam logic [63:0] IDLE_DATA = 64'h0000_0000_0000_001e;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // State and datapath registers
  logic [0:0]           state_q, state_d;
  logic [3:0]           exp_idx_q, exp_idx_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [MSG_WIDTH-1:0] buf_q, buf_d;
  logic [MSG_WIDTH-1:0] msg_data_q, msg_data_d;
  logic                 msg_valid_q, msg_valid_d;
  logic                 msg_err_q, msg_err_d;
  logic                 out_valid_q;
  logic [1:0]           out_hdr_q, out_hdr_d;
  logic [63:0]          out_data_q, out_data_d;

  // Decoded fields of the incoming block
  logic            is_ipg;
  logic [3:0]      blk_idx;
  logic            blk_last;
  logic [31:0]     blk_payload;
  logic            blk_start;
  logic [TO_W-1:0] to_inc;

  // Control decisions from the next-state logic
  logic wr_en;
  logic complete;
  logic err;

  assign is_ipg      = in_valid && (in_hdr == HDR_CTRL) && (in_data[7:0] == IPG_BT);
  assign blk_idx     = in_data[11:8];
  assign blk_last    = in_data[12];
  assign blk_payload = in_data[63:32];
  assign blk_start   = (blk_idx == 4'd0) && !blk_last;
  assign to_inc      = to_cnt_q + TO_W'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (in_valid) begin
      state_q <= state_d;
    end
  end

  // Next-state logic: chunk sequencing, error detection and timeout
  always_comb begin
    state_d   = state_q;
    exp_idx_d = exp_idx_q;
    to_cnt_d  = to_cnt_q;
    wr_en     = 1'b0;
    complete  = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a clean chunk 0 opens a message; anything else is dropped.
        if (is_ipg && blk_start) begin
          wr_en     = 1'b1;
          exp_idx_d = 4'd1;
          to_cnt_d  = '0;
          state_d   = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (is_ipg) begin
          // In sequence, and the last flag is set exactly on chunk 15.
          if ((blk_idx == exp_idx_q) && (blk_last == (blk_idx == 4'd15))) begin
            wr_en    = 1'b1;
            to_cnt_d = '0;
            if (blk_idx == 4'd15) begin
              complete  = 1'b1;
              exp_idx_d = 4'd0;
              state_d   = ST_IDLE;
            end else begin
              exp_idx_d = exp_idx_q + 4'd1;
            end
          end else begin
            err = 1'b1;
            // A fresh chunk 0 restarts collection in the same cycle.
            if (blk_start) begin
              wr_en     = 1'b1;
              exp_idx_d = 4'd1;
              to_cnt_d  = '0;
              state_d   = ST_COLLECT;
            end else begin
              exp_idx_d = 4'd0;
              to_cnt_d  = '0;
              state_d   = ST_IDLE;
            end
          end
        end else if (in_valid) begin
          if (to_inc == TO_W'(TIMEOUT)) begin
            err       = 1'b1;
            exp_idx_d = 4'd0;
            to_cnt_d  = '0;
            state_d   = ST_IDLE;
          end else begin
            to_cnt_d = to_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: pass-through substitution, buffer write and message events
  always_comb begin
    out_hdr_d   = is_ipg ? HDR_CTRL : in_hdr;
    out_data_d  = is_ipg ? IDLE_DATA : in_data;
    buf_d       = buf_q;
    if (wr_en) begin
      buf_d[{blk_idx, 5'd0} +: 32] = blk_payload;
    end
    msg_data_d  = complete ? buf_d : msg_data_q;
    msg_valid_d = complete;
    msg_err_d   = err;
  end

  // Datapath registers; the pass-through fields hold while no block arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_idx_q   <= 4'd0;
      to_cnt_q    <= '0;
      buf_q       <= '0;
      msg_data_q  <= '0;
      msg_valid_q <= 1'b0;
      msg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_hdr_q   <= 2'b00;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= in_valid;
      msg_valid_q <= in_valid && msg_valid_d;
      msg_err_q   <= in_valid && msg_err_d;
      if (in_valid) begin
        exp_idx_q  <= exp_idx_d;
        to_cnt_q   <= to_cnt_d;
        buf_q      <= buf_d;
        msg_data_q <= msg_data_d;
        out_hdr_q  <= out_hdr_d;
        out_data_q <= out_data_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_hdr   = out_hdr_q;
  assign out_data  = out_data_q;
  assign msg_data  = msg_data_q;
  assign msg_valid = msg_valid_q;
  assign msg_err   = msg_err_q;

`ifdef IPG_RX_STATS_EN
  logic [15:0] msg_count_q;
  logic [15:0] err_count_q;

  // Saturating completion / discard counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_count_q <= 16'd0;
      err_count_q <= 16'd0;
    end else begin
      if (msg_valid_q && (msg_count_q != 16'hFFFF)) begin
        msg_count_q <= msg_count_q + 16'd1;
      end
      if (msg_err_q && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign msg_count = msg_count_q;
  assign err_count = err_count_q;
`endif

endmodule
`default_nettype wire
